ii_display_unpack: RTL

Parametrised successor to the integral image VGA display path. The block fetches integral-image words from block RAM in raster order as the display requests pixels. It recovers each original pixel with the full four-corner inverse, p = I(x,y) - I(x-1,y) - I(x,y-1) + I(x-1,y-1), and drives a greyscale pixel to the VGA output. Compared with the previous block it adds:
- configurable image size, data widths and RAM read latency;
- an explicit previous-row line buffer;
- a raw/scaled-integral debug mode;
- per-frame flush and a frame-complete flag.

---
 rtl/ii_display_unpack_if.sv | 40 ++++
 rtl/ii_display_unpack.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ii_display_unpack_if.sv
`default_nettype none
// ============================================================================
// Module   : ii_display_unpack_if
// Purpose  : Bundles the frame control, integral-image RAM read port and
//            pixel output of ii_display_unpack.
// Ports    : frame_start, pix_req, mode  - display timing / mode controls
//            ii_addr, ii_rden, ii_rddata - integral-image RAM read port
//            pix_valid, pix_data, rgb    - pixel output (greyscale)
//            frame_done                  - last pixel of frame pulse
// Modports : slave  - the display-unpack block
//            master - the environment (timing generator + RAM)
// Revision : 1.0 - initial release
// ============================================================================
interface ii_display_unpack_if #(
  parameter int ADDR_W = 15,
  parameter int II_W   = 20,
  parameter int PIX_W  = 8
);
  logic              frame_start;
  logic              pix_req;
  logic              mode;
  logic [ADDR_W-1:0] ii_addr;
  logic              ii_rden;
  logic [II_W-1:0]   ii_rddata;
  logic              pix_valid;
  logic [PIX_W-1:0]  pix_data;
  logic [11:0]       rgb;
  logic              frame_done;

  modport slave (
    input  frame_start, pix_req, mode, ii_rddata,
    output ii_addr, ii_rden, pix_valid, pix_data, rgb, frame_done
  );

  modport master (
    output frame_start, pix_req, mode, ii_rddata,
    input  ii_addr, ii_rden, pix_valid, pix_data, rgb, frame_done
  );
endinterface
`default_nettype wire

// File: rtl/ii_display_unpack.sv
`default_nettype none
// ============================================================================
// Module   : ii_display_unpack
// Purpose  : Fetches integral-image words in raster order as the display asks
//            for pixels and recovers each pixel with the four-corner inverse
//            p = I(x,y) - I(x-1,y) - I(x,y-1) + I(x-1,y-1). A debug mode shows
//            the raw integral word shifted right by RAW_SHIFT instead.
// Ports    : clk_vga - pixel clock
//            rst     - synchronous reset, active-low
//            bus     - ii_display_unpack_if.slave: frame_start, pix_req, mode,
//                      RAM read port (ii_addr/ii_rden/ii_rddata), pixel output
//                      (pix_valid/pix_data/rgb) and frame_done
// Revision : 1.0 - initial release
// ============================================================================
module ii_display_unpack #(
  parameter int IMG_W     = 160,
  parameter int IMG_H     = 120,
  parameter int II_W      = 20,
  parameter int PIX_W     = 8,
  parameter int ADDR_W    = 15,
  parameter int RD_LAT    = 1,
  parameter int RAW_SHIFT = 12
) (
  input  wire                clk_vga,
  input  wire                rst,
  ii_display_unpack_if.slave bus
);

  localparam int               COL_W    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int               ROW_W    = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PIX_MAX  = '1;

  // Request stage
  logic [COL_W-1:0]  col_q;
  logic [ROW_W-1:0]  row_q;
  logic              exh_q;
  logic [ADDR_W-1:0] addr_cnt_q;
  logic [ADDR_W-1:0] ii_addr_q;
  logic              ii_rden_q;

  // Tag pipeline: index 0 is loaded alongside ii_rden, index RD_LAT lines up
  // with the returning RAM word. Blank (exhausted) requests travel through it
  // too so that border pixels leave in request order.
  logic              tag_v_q   [0:RD_LAT];
  logic              tag_b_q   [0:RD_LAT];
  logic [COL_W-1:0]  tag_col_q [0:RD_LAT];
  logic [ROW_W-1:0]  tag_row_q [0:RD_LAT];

  // Compute stage
  logic [II_W-1:0]   linebuf_q [0:IMG_W-1];
  logic [II_W-1:0]   left_q;
  logic [II_W-1:0]   diag_q;
  logic              cv_q;
  logic              cblank_q;
  logic              cdone_q;
  logic [PIX_W-1:0]  cpix_q;

  // Output stage
  logic              pix_valid_q;
  logic [PIX_W-1:0]  pix_data_q;
  logic [11:0]       rgb_q;
  logic              frame_done_q;

  // Combinational next values
  logic              req_ok_d;
  logic              rd_go_d;
  logic              cmp_v_d;
  logic              cmp_b_d;
  logic [COL_W-1:0]  cmp_col_d;
  logic [ROW_W-1:0]  cmp_row_d;
  logic [II_W-1:0]   up_d;
  logic [II_W-1:0]   left_d;
  logic [II_W-1:0]   diag_d;
  logic [II_W-1:0]   sum_d;
  logic [II_W-1:0]   sel_d;
  logic [PIX_W-1:0]  cmp_pix_d;
  logic              cmp_done_d;
  logic [PIX_W-1:0]  pix_data_d;

  always_comb begin
    // frame_start drops a simultaneous request
    req_ok_d   = bus.pix_req && !bus.frame_start;
    rd_go_d    = req_ok_d && !exh_q;

    // frame_start also discards the word returning this cycle
    cmp_v_d    = tag_v_q[RD_LAT] && !bus.frame_start;
    cmp_b_d    = tag_b_q[RD_LAT];
    cmp_col_d  = tag_col_q[RD_LAT];
    cmp_row_d  = tag_row_q[RD_LAT];

    // Neighbours outside the image read as zero; row 0 masks whatever the
    // line buffer still holds from the previous frame.
    up_d       = (cmp_row_d == '0) ? '0 : linebuf_q[cmp_col_d];
    left_d     = (cmp_col_d == '0) ? '0 : left_q;
    diag_d     = ((cmp_col_d == '0) || (cmp_row_d == '0)) ? '0 : diag_q;
    sum_d      = bus.ii_rddata - left_d - up_d + diag_d;

    sel_d      = bus.mode ? (bus.ii_rddata >> RAW_SHIFT) : sum_d;
    // Anything that does not fit (including a wrapped negative) shows white
    cmp_pix_d  = (|sel_d[II_W-1:PIX_W]) ? PIX_MAX : sel_d[PIX_W-1:0];
    cmp_done_d = (cmp_col_d == COL_LAST) && (cmp_row_d == ROW_LAST) && !cmp_b_d;

    pix_data_d = (cv_q && !cblank_q) ? cpix_q : '0;
  end

  always_ff @(posedge clk_vga) begin
    if (!rst) begin
      col_q        <= '0;
      row_q        <= '0;
      exh_q        <= 1'b0;
      addr_cnt_q   <= '0;
      ii_addr_q    <= '0;
      ii_rden_q    <= 1'b0;
      for (int k = 0; k <= RD_LAT; k++) begin
        tag_v_q[k]   <= 1'b0;
        tag_b_q[k]   <= 1'b0;
        tag_col_q[k] <= '0;
        tag_row_q[k] <= '0;
      end
      for (int i = 0; i < IMG_W; i++) begin
        linebuf_q[i] <= '0;
      end
      left_q       <= '0;
      diag_q       <= '0;
      cv_q         <= 1'b0;
      cblank_q     <= 1'b0;
      cdone_q      <= 1'b0;
      cpix_q       <= '0;
      pix_valid_q  <= 1'b0;
      pix_data_q   <= '0;
      rgb_q        <= '0;
      frame_done_q <= 1'b0;
    end else begin
      // Request stage: address kept as a running counter beside col/row
      ii_rden_q <= rd_go_d;
      if (rd_go_d) begin
        ii_addr_q <= addr_cnt_q;
      end
      if (bus.frame_start) begin
        col_q      <= '0;
        row_q      <= '0;
        exh_q      <= 1'b0;
        addr_cnt_q <= '0;
      end else if (rd_go_d) begin
        addr_cnt_q <= addr_cnt_q + ADDR_W'(1);
        if (col_q == COL_LAST) begin
          col_q <= '0;
          if (row_q == ROW_LAST) begin
            exh_q <= 1'b1;
          end else begin
            row_q <= row_q + ROW_W'(1);
          end
        end else begin
          col_q <= col_q + COL_W'(1);
        end
      end

      tag_v_q[0]   <= req_ok_d;
      tag_b_q[0]   <= exh_q;
      tag_col_q[0] <= col_q;
      tag_row_q[0] <= row_q;
      for (int k = 1; k <= RD_LAT; k++) begin
        tag_v_q[k]   <= tag_v_q[k-1] && !bus.frame_start;
        tag_b_q[k]   <= tag_b_q[k-1];
        tag_col_q[k] <= tag_col_q[k-1];
        tag_row_q[k] <= tag_row_q[k-1];
      end

      // Compute stage
      cv_q     <= cmp_v_d;
      cblank_q <= cmp_b_d;
      cdone_q  <= cmp_done_d;
      cpix_q   <= cmp_pix_d;
      if (bus.frame_start) begin
        left_q <= '0;
        diag_q <= '0;
      end else if (cmp_v_d && !cmp_b_d) begin
        linebuf_q[cmp_col_d] <= bus.ii_rddata;
        left_q               <= bus.ii_rddata;
        diag_q               <= up_d;
      end

      // Output stage
      pix_valid_q  <= cv_q;
      pix_data_q   <= pix_data_d;
      rgb_q        <= {3{pix_data_d[PIX_W-1 -: 4]}};
      frame_done_q <= cv_q && cdone_q;
    end
  end

  assign bus.ii_addr    = ii_addr_q;
  assign bus.ii_rden    = ii_rden_q;
  assign bus.pix_valid  = pix_valid_q;
  assign bus.pix_data   = pix_data_q;
  assign bus.rgb        = rgb_q;
  assign bus.frame_done = frame_done_q;

endmodule
`default_nettype wire
